channel_fifo: RTL
=================

Name: channel_fifo

Overview:
- Buffered point-to-point channel. Sits directly upstream of the reduction stages (e.g. the 4-element channel reducer) and feeds their `in_*` channel ports.
- A producer pushes words with a valid/ready write handshake. A consumer pops words with a valid/ready read handshake.
- Popped data is registered: it appears on `out_data` one cycle after the pop and holds until the next pop. This matches consumers that pulse `read_valid`, then use `out_data` in the following state.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of storage entries; power of two, minimum 2.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, reset, asynchronous, active-high. Consumers' channel-reset outputs (`*_rst`) are ORed into this at integration.
- in_data, input, WIDTH, write data from producer.
- write_valid, input, 1, producer requests a push this cycle.
- write_ready, output, 1, high when not full.
- read_valid, input, 1, consumer requests a pop this cycle.
- read_ready, output, 1, high when not empty.
- out_data, output, WIDTH, registered head word from the most recent accepted pop.
- count, output, $clog2(DEPTH+1), current occupancy.
- overflow, output, 1, sticky; set when a push is attempted while full.
- underflow, output, 1, sticky; set when a pop is attempted while empty.

Behaviour:
- Reset (asynchronous assert, synchronous-edge release):
  - wr_ptr = rd_ptr = 0, count = 0, out_data = 0.
  - overflow = 0, underflow = 0.
  - write_ready = 1, read_ready = 0.
  - Storage contents are don't-care.
- write_ready = (count != DEPTH) and read_ready = (count != 0). Both are combinational from count only, with no input-to-output path.
- Push accepted = write_valid && write_ready. On the edge: mem[wr_ptr] <= in_data; wr_ptr advances by 1, wrapping DEPTH-1 to 0.
- Pop accepted = read_valid && read_ready. On the edge: out_data <= mem[rd_ptr]; rd_ptr advances by 1 with the same wrap.
- Pop latency: pop at cycle t gives the value on out_data at t+1. out_data holds until the next accepted pop.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop, non-empty and non-full: both accepted, count unchanged. The popped word is the old head, never the word being written.
- Empty with push and pop in the same cycle: push accepted, pop rejected (no bypass). underflow sets, out_data holds, count becomes 1.
- Full with push and pop in the same cycle: pop accepted, push rejected. overflow sets, count becomes DEPTH-1, in_data is not stored.
- Rejected push or pop never changes pointers, count or memory.
- FIFO order is preserved across pointer wrap.
- overflow and underflow are cleared only by rst.
- rst mid-stream: all queued words are discarded immediately. read_ready drops in the same cycle rst asserts; write_ready = 1.
- Read and write addresses come straight from the pointers; there is no separate state machine beyond the pointer/count registers.

Decomposition:
- Shared package:
  - channel handshake constants: CHANNEL_DATA_WIDTH = 32, default DEPTH;
  - a function computing the count width (clog2(DEPTH+1)).
- One natural sub-module: `channel_fifo_mem`, a simple dual-port register array with write port (waddr, wdata, wen) and registered read port (raddr, ren, rdata). `channel_fifo` holds pointers, count, flags and handshake logic.

Test Plan:
- Reset release -> write_ready=1, read_ready=0, count=0, out_data=0, flags=0.
- Push 1,2,3,4 on consecutive cycles, then pop four times with one-cycle pulses in the consumer's 3-state pattern -> out_data shows 1,2,3,4 each one cycle after its pop. A connected 4-element reducer outputs 10.
- Push 16 words (DEPTH=16), then a 17th attempt with value 99 -> write_ready=0 after the 16th, overflow=1, count=16. Draining 16 pops yields the original order, never 99.
- Empty FIFO with push 7 and pop in the same cycle -> count=1, underflow=1, out_data unchanged. The next pop gives out_data=7 one cycle later.
- Steady simultaneous push and pop for 40 cycles at count=5 (crossing wrap twice) -> count stays 5 and the output sequence equals the input sequence delayed by 5 words.
- Assert rst asynchronously mid-cycle with count=9 -> count=0, read_ready=0 immediately without waiting for a clock edge. Post-reset push 42 then pop -> out_data=42.

Source files
------------

// File: rtl/channel_fifo_pkg.sv
// Shared channel constants and helpers for the buffered channel FIFO.
package channel_fifo_pkg;

  localparam int unsigned CHANNEL_DATA_WIDTH = 32;
  localparam int unsigned CHANNEL_FIFO_DEPTH = 16;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// Simple dual-port register array with a registered read port.
// Ports:
//   clk, rst          - clock, async active-high reset (read register only)
//   waddr/wdata/wen   - write port, stored on the rising edge when wen
//   raddr/ren         - read port, rdata loads mem[raddr] on the edge when ren
//   rdata             - registered read data, holds between reads
module channel_fifo_mem #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wen,
  input  logic [AW-1:0]    raddr,
  input  logic             ren,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds the last read word until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (ren) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/channel_fifo.sv
// Buffered point-to-point channel FIFO with valid/ready push and pop.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   in_data, write_valid      - producer push request and data
//   write_ready               - not full (from count only)
//   read_valid                - consumer pop request
//   read_ready                - not empty (from count only)
//   out_data                  - registered word from the most recent accepted pop
//   count                     - current occupancy
//   overflow, underflow       - sticky push-while-full / pop-while-empty flags
module channel_fifo
  import channel_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = CHANNEL_DATA_WIDTH,
  parameter int unsigned DEPTH = CHANNEL_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                in_data,
  input  logic                            write_valid,
  output logic                            write_ready,
  input  logic                            read_valid,
  output logic                            read_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_c, pop_c;

  // Handshake readiness depends only on occupancy, never on inputs.
  assign write_ready = (count_q != CW'(DEPTH));
  assign read_ready  = (count_q != '0);
  assign push_c      = write_valid && write_ready;
  assign pop_c       = read_valid && read_ready;

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (write_valid && !write_ready);
    underflow_d = underflow_q | (read_valid && !read_ready);
    // DEPTH is a power of two, so pointer wrap is the natural rollover.
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all queued words immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Read addresses the old head, so a same-cycle push is never bypassed.
  channel_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .wen   (push_c),
    .raddr (rd_ptr_q),
    .ren   (pop_c),
    .rdata (out_data)
  );

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
